// File: rtl/wpb_pkg.sv
// Shared types and helpers for the weight prefetch buffer.
package wpb_pkg;

    typedef enum logic [1:0] {
        WPB_IDLE = 2'd0,
        WPB_FILL = 2'd1,
        WPB_FULL = 2'd2
    } wpb_state_t;

    // Row-counter width; at least one bit so a single-row tile still elaborates.
    function automatic int unsigned wpb_cnt_w(input int unsigned rows);
        return (rows <= 1) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/wpb_valid_delay.sv
// Aligns the SRAM read enable with the cycle its read data arrives.
module wpb_valid_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            // Single-stage delay.
            always_ff @(posedge clk) begin
                if (!rstn) sr <= '0;
                else       sr <= d;
            end
        end else begin : g_many
            // Multi-stage shift, newest bit enters at position 0.
            always_ff @(posedge clk) begin
                if (!rstn) sr <= '0;
                else       sr <= {sr[DEPTH-2:0], d};
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/weight_prefetch_buffer.sv
// Weight tile receiver: fills a shadow bank from SRAM read data and moves it
// to the active bank on swap so the next tile can prefetch during compute.
// Optional feature macro: WPB_ZERO_TILE_DETECT_EN (flags all-zero active tiles).
module weight_prefetch_buffer
    import wpb_pkg::*;
#(
    parameter int unsigned MAC_ROW    = 16,
    parameter int unsigned MAC_COL    = 16,
    parameter int unsigned W_BITWIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    w_prefetch_in,
    input  logic                                    w_read_en_in,
    input  logic [MAC_COL*W_BITWIDTH-1:0]           w_rdata_in,
    input  logic                                    swap_in,
    output logic                                    w_ready_out,
    output logic                                    w_busy_out,
    output logic                                    w_valid_out,
    output logic [MAC_ROW*MAC_COL*W_BITWIDTH-1:0]   w_array_out,
    output logic                                    w_err_out,
    output logic                                    w_zero_tile_out
);

    localparam int unsigned ROW_W    = MAC_COL * W_BITWIDTH;
    localparam int unsigned CNT_W    = wpb_cnt_w(MAC_ROW);
    localparam int unsigned LAST_ROW = MAC_ROW - 1;

    wpb_state_t                     state;
    wpb_state_t                     state_next;
    logic [CNT_W-1:0]               row_cnt;
    logic [MAC_ROW-1:0][ROW_W-1:0]  shadow;
    logic [MAC_ROW-1:0][ROW_W-1:0]  active;
    logic                           valid;
    logic                           err;
    logic                           beat;
    logic                           last_row_c;
    logic                           fill_start_c;
    logic                           row_wr_c;
    logic                           swap_go_c;
    logic                           err_set_c;

    wpb_valid_delay #(
        .DEPTH (RD_LATENCY)
    ) u_valid_delay (
        .clk  (clk),
        .rstn (rstn),
        .d    (w_read_en_in),
        .q    (beat)
    );

    assign last_row_c = (row_cnt == CNT_W'(LAST_ROW));

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= WPB_IDLE;
        else       state <= state_next;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next   = state;
        fill_start_c = 1'b0;
        row_wr_c     = 1'b0;
        swap_go_c    = 1'b0;
        err_set_c    = 1'b0;
        case (state)
            WPB_IDLE: begin
                if (w_prefetch_in) begin
                    state_next   = WPB_FILL;
                    fill_start_c = 1'b1;
                end
                if (beat) err_set_c = 1'b1;
            end
            WPB_FILL: begin
                if (w_prefetch_in) begin
                    fill_start_c = 1'b1;
                    err_set_c    = 1'b1;
                end else if (beat) begin
                    row_wr_c = 1'b1;
                    if (last_row_c) state_next = WPB_FULL;
                end
            end
            WPB_FULL: begin
                if (swap_in) begin
                    swap_go_c = 1'b1;
                    if (w_prefetch_in) begin
                        state_next   = WPB_FILL;
                        fill_start_c = 1'b1;
                    end else begin
                        state_next = WPB_IDLE;
                    end
                end else if (w_prefetch_in) begin
                    err_set_c = 1'b1;
                end
                if (beat) err_set_c = 1'b1;
            end
            default: state_next = WPB_IDLE;
        endcase
    end

    // Row counter; parks at zero after the last row instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rstn)             row_cnt <= '0;
        else if (fill_start_c) row_cnt <= '0;
        else if (row_wr_c)     row_cnt <= last_row_c ? '0 : row_cnt + CNT_W'(1);
    end

    // Shadow bank capture, one row per accepted beat.
    always_ff @(posedge clk) begin
        if (!rstn)         shadow          <= '0;
        else if (row_wr_c) shadow[row_cnt] <= w_rdata_in;
    end

    // Active bank and its valid flag, updated only on swap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active <= '0;
            valid  <= 1'b0;
        end else if (swap_go_c) begin
            active <= shadow;
            valid  <= 1'b1;
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk) begin
        if (!rstn)          err <= 1'b0;
        else if (err_set_c) err <= 1'b1;
    end

`ifdef WPB_ZERO_TILE_DETECT_EN
    logic nonzero;
    logic zero_tile;

    // Accumulate whether any weight of the shadow tile is nonzero.
    always_ff @(posedge clk) begin
        if (!rstn)             nonzero <= 1'b0;
        else if (fill_start_c) nonzero <= 1'b0;
        else if (row_wr_c)     nonzero <= nonzero | (|w_rdata_in);
    end

    // Zero flag follows the active bank.
    always_ff @(posedge clk) begin
        if (!rstn)          zero_tile <= 1'b0;
        else if (swap_go_c) zero_tile <= ~nonzero;
    end

    assign w_zero_tile_out = zero_tile;
`else
    assign w_zero_tile_out = 1'b0;
`endif

    assign w_busy_out  = (state == WPB_FILL);
    assign w_ready_out = (state == WPB_FULL);
    assign w_valid_out = valid;
    assign w_err_out   = err;
    assign w_array_out = active;

endmodule

// File: tb/tb_weight_prefetch_buffer.sv
// Directed bench for weight_prefetch_buffer (4x4 tile, 8-bit weights, latency 1).
module tb_weight_prefetch_buffer;

    localparam int unsigned MR    = 4;
    localparam int unsigned MC    = 4;
    localparam int unsigned WB    = 8;
    localparam int unsigned RL    = 1;
    localparam int unsigned ROW_W = MC * WB;
    localparam int unsigned ARR_W = MR * MC * WB;

`ifdef WPB_ZERO_TILE_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    localparam logic [ARR_W-1:0] Z  = '0;
    localparam logic [ARR_W-1:0] A1 = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [ARR_W-1:0] A2 = 128'h201F1E1D_1C1B1A19_18171615_14131211;
    localparam logic [ARR_W-1:0] A3 = 128'h302F2E2D_2C2B2A29_28272625_24232221;
    localparam logic [ARR_W-1:0] A4 = 128'h504F4E4D_4C4B4A49_48474645_44434241;

    logic              clk = 1'b0;
    logic              rstn;
    logic              w_prefetch_in;
    logic              w_read_en_in;
    logic [ROW_W-1:0]  w_rdata_in;
    logic              swap_in;
    logic              w_ready_out;
    logic              w_busy_out;
    logic              w_valid_out;
    logic [ARR_W-1:0]  w_array_out;
    logic              w_err_out;
    logic              w_zero_tile_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             rn;
        logic             pf;
        logic             re;
        logic [ROW_W-1:0] d;
        logic             sw;
        logic             rdy;
        logic             bsy;
        logic             vld;
        logic             err;
        logic [ARR_W-1:0] arr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    weight_prefetch_buffer #(
        .MAC_ROW    (MR),
        .MAC_COL    (MC),
        .W_BITWIDTH (WB),
        .RD_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .w_prefetch_in   (w_prefetch_in),
        .w_read_en_in    (w_read_en_in),
        .w_rdata_in      (w_rdata_in),
        .swap_in         (swap_in),
        .w_ready_out     (w_ready_out),
        .w_busy_out      (w_busy_out),
        .w_valid_out     (w_valid_out),
        .w_array_out     (w_array_out),
        .w_err_out       (w_err_out),
        .w_zero_tile_out (w_zero_tile_out)
    );

    task automatic check(input string nm, input logic [ARR_W-1:0] act, input logic [ARR_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rn, input logic pf, input logic re, input logic [ROW_W-1:0] d,
                       input logic sw, input logic rdy, input logic bsy, input logic vld,
                       input logic err, input logic [ARR_W-1:0] arr);
        vec_t v;
        v.rn = rn; v.pf = pf; v.re = re; v.d = d; v.sw = sw;
        v.rdy = rdy; v.bsy = bsy; v.vld = vld; v.err = err; v.arr = arr;
        vecs.push_back(v);
    endtask

    // Fill one tile, wait (bounded) for ready, swap, and check the result.
    task automatic fill_and_swap(input logic [ARR_W-1:0] tile, input logic exp_zero, input string tag);
        int t;
        w_prefetch_in = 1'b1;
        step();
        w_prefetch_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_read_en_in = 1'b1;
            w_rdata_in   = (i > 0) ? tile[(i-1)*32 +: 32] : '0;
            step();
        end
        w_read_en_in = 1'b0;
        w_rdata_in   = tile[96 +: 32];
        step();
        w_rdata_in = '0;
        t = 0;
        while (!w_ready_out && t < 8) begin
            step();
            t++;
        end
        check($sformatf("%s_ready", tag), ARR_W'(w_ready_out), ARR_W'(1'b1));
        swap_in = 1'b1;
        step();
        swap_in = 1'b0;
        check($sformatf("%s_array", tag), w_array_out, tile);
        check($sformatf("%s_valid", tag), ARR_W'(w_valid_out), ARR_W'(1'b1));
        check($sformatf("%s_zero", tag), ARR_W'(w_zero_tile_out), ARR_W'(exp_zero & ZD));
    endtask

    initial begin
        rstn          = 1'b0;
        w_prefetch_in = 1'b0;
        w_read_en_in  = 1'b0;
        w_rdata_in    = '0;
        swap_in       = 1'b0;

        //  rn pf re data          sw   rdy bsy vld err arr
        // Fill tile 1, hold FULL, then swap + prefetch together, fill tile 2, swap.
        add(1, 1, 0, 32'h0,        0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'h0,        0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'h04030201, 0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'h08070605, 0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'h0C0B0A09, 0,   0, 1, 0, 0, Z);
        add(1, 0, 0, 32'h100F0E0D, 0,   1, 0, 0, 0, Z);
        add(1, 0, 0, 32'h0,        0,   1, 0, 0, 0, Z);
        add(1, 1, 0, 32'h0,        1,   0, 1, 1, 0, A1);
        add(1, 0, 1, 32'h0,        0,   0, 1, 1, 0, A1);
        add(1, 0, 1, 32'h14131211, 0,   0, 1, 1, 0, A1);
        add(1, 0, 1, 32'h18171615, 0,   0, 1, 1, 0, A1);
        add(1, 0, 1, 32'h1C1B1A19, 0,   0, 1, 1, 0, A1);
        add(1, 0, 0, 32'h201F1E1D, 0,   1, 0, 1, 0, A1);
        add(1, 0, 0, 32'h0,        1,   0, 0, 1, 0, A2);
        // Swap while IDLE is ignored.
        add(1, 0, 0, 32'h0,        1,   0, 0, 1, 0, A2);
        // Tile 3, prefetch while FULL, stray beat while FULL, then swap.
        add(1, 1, 0, 32'h0,        0,   0, 1, 1, 0, A2);
        add(1, 0, 1, 32'h0,        0,   0, 1, 1, 0, A2);
        add(1, 0, 1, 32'h24232221, 0,   0, 1, 1, 0, A2);
        add(1, 0, 1, 32'h28272625, 0,   0, 1, 1, 0, A2);
        add(1, 0, 1, 32'h2C2B2A29, 0,   0, 1, 1, 0, A2);
        add(1, 0, 0, 32'h302F2E2D, 0,   1, 0, 1, 0, A2);
        add(1, 1, 0, 32'h0,        0,   1, 0, 1, 1, A2);
        add(1, 0, 1, 32'h0,        0,   1, 0, 1, 1, A2);
        add(1, 0, 0, 32'hFFFFFFFF, 0,   1, 0, 1, 1, A2);
        add(1, 0, 0, 32'h0,        1,   0, 0, 1, 1, A3);
        // Reset mid-fill with a read still in flight.
        add(1, 1, 0, 32'h0,        0,   0, 1, 1, 1, A3);
        add(1, 0, 1, 32'h0,        0,   0, 1, 1, 1, A3);
        add(1, 0, 1, 32'hAAAAAAAA, 0,   0, 1, 1, 1, A3);
        add(0, 0, 1, 32'hBBBBBBBB, 0,   0, 0, 0, 0, Z);
        add(1, 0, 0, 32'hCCCCCCCC, 0,   0, 0, 0, 0, Z);
        add(1, 0, 0, 32'h0,        0,   0, 0, 0, 0, Z);
        // Beat while IDLE.
        add(1, 0, 1, 32'h0,        0,   0, 0, 0, 0, Z);
        add(1, 0, 0, 32'h11111111, 0,   0, 0, 0, 1, Z);
        add(0, 0, 0, 32'h0,        0,   0, 0, 0, 0, Z);
        // Prefetch during FILL after two beats restarts the tile.
        add(1, 1, 0, 32'h0,        0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'h0,        0,   0, 1, 0, 0, Z);
        add(1, 0, 1, 32'hDEADBEEF, 0,   0, 1, 0, 0, Z);
        add(1, 0, 0, 32'hCAFEF00D, 0,   0, 1, 0, 0, Z);
        add(1, 1, 0, 32'h0,        0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h0,        0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h44434241, 0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h48474645, 0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h4C4B4A49, 0,   0, 1, 0, 1, Z);
        add(1, 0, 0, 32'h504F4E4D, 0,   1, 0, 0, 1, Z);
        add(1, 0, 0, 32'h0,        1,   0, 0, 1, 1, A4);
        // Prefetch and beat in the same IDLE cycle: beat dropped, error.
        add(0, 0, 0, 32'h0,        0,   0, 0, 0, 0, Z);
        add(1, 0, 1, 32'h0,        0,   0, 0, 0, 0, Z);
        add(1, 1, 0, 32'h99999999, 0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h0,        0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h04030201, 0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h08070605, 0,   0, 1, 0, 1, Z);
        add(1, 0, 1, 32'h0C0B0A09, 0,   0, 1, 0, 1, Z);
        add(1, 0, 0, 32'h100F0E0D, 0,   1, 0, 0, 1, Z);
        add(1, 0, 0, 32'h0,        1,   0, 0, 1, 1, A1);

        // Reset state.
        repeat (2) step();
        check("rst_ready", ARR_W'(w_ready_out), Z);
        check("rst_busy",  ARR_W'(w_busy_out),  Z);
        check("rst_valid", ARR_W'(w_valid_out), Z);
        check("rst_err",   ARR_W'(w_err_out),   Z);
        check("rst_array", w_array_out,          Z);
        check("rst_zero",  ARR_W'(w_zero_tile_out), Z);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            rstn          = vecs[i].rn;
            w_prefetch_in = vecs[i].pf;
            w_read_en_in  = vecs[i].re;
            w_rdata_in    = vecs[i].d;
            swap_in       = vecs[i].sw;
            step();
            check($sformatf("v%0d_ready", i), ARR_W'(w_ready_out), ARR_W'(vecs[i].rdy));
            check($sformatf("v%0d_busy",  i), ARR_W'(w_busy_out),  ARR_W'(vecs[i].bsy));
            check($sformatf("v%0d_valid", i), ARR_W'(w_valid_out), ARR_W'(vecs[i].vld));
            check($sformatf("v%0d_err",   i), ARR_W'(w_err_out),   ARR_W'(vecs[i].err));
            check($sformatf("v%0d_array", i), w_array_out,          vecs[i].arr);
        end

        rstn          = 1'b1;
        w_prefetch_in = 1'b0;
        w_read_en_in  = 1'b0;
        w_rdata_in    = '0;
        swap_in       = 1'b0;

        // Zero-tile detection across consecutive tiles.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        fill_and_swap(Z, 1'b1, "zero_a");
        fill_and_swap(128'h1, 1'b0, "one_lsb");
        fill_and_swap(Z, 1'b1, "zero_b");
        check("zd_err", ARR_W'(w_err_out), Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
